angle_to_vector: RTL and testbench

//  Inverse of the cartesian-to-angle path: converts a 16-bit binary angle (full circle = 2^16)
//  and an unsigned magnitude into signed cartesian (x, y). Quarter-wave sine LUT with quadrant

---
 rtl/angle_to_vector_pkg.sv | 62 ++++++
 rtl/angle_to_vector_sin_quarter_lut.sv | 56 +++++
 rtl/angle_to_vector.sv | 175 +++++++++++++++++
 tb/tb_angle_to_vector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/angle_to_vector_pkg.sv
// ---------------------------------------------------------------------------
// angle_to_vector_pkg
//   Shared constants and types for the binary-angle <-> cartesian blocks.
//   Used by angle_to_vector and by the cartesian-to-angle block.
//
//   Contents:
//     ANGLE_W, FULL_CIRCLE, QUADRANT_SIZE  binary-angle geometry (2^16 = 360 deg)
//     LUT_AW_DEFAULT, LUT_DEPTH            quarter-wave LUT geometry (257 entries)
//     SAMPLE_W                             LUT sample width (0..32767, unsigned)
//     DEFAULT_LUT_FILE                     name of the generated LUT image
//     quadrant_t                           quadrant encoding Q0..Q3
//     sin_q15()                            elaboration-time quarter-wave sample
// ---------------------------------------------------------------------------
package angle_to_vector_pkg;

    localparam int ANGLE_W        = 16;
    localparam int FULL_CIRCLE    = 1 << 16;
    localparam int QUADRANT_SIZE  = 1 << 14;
    localparam int LUT_AW_DEFAULT = 8;
    localparam int LUT_DEPTH      = (1 << LUT_AW_DEFAULT) + 1;
    localparam int SAMPLE_W       = 15;

    localparam string DEFAULT_LUT_FILE = "sin_lut.mem";

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // pi in Q30 fixed point
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(32767 * sin(idx * pi / 2^(aw+1))), evaluated at elaboration time.
    // Taylor series in Q30; x <= pi/2 keeps every product inside 63 bits and
    // the residual error is far below half an LSB of the 15-bit result.
    function automatic logic [SAMPLE_W-1:0] sin_q15(input int idx, input int aw);
        longint xq;
        longint x2;
        longint term;
        longint sum;
        longint val;
        xq   = (longint'(idx) * PI_Q30) >>> (aw + 1);
        x2   = (xq * xq) >>> 30;
        term = xq;
        sum  = xq;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        val = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
        if (val > 64'sd32767) begin
            val = 64'sd32767;
        end
        if (val < 64'sd0) begin
            val = 64'sd0;
        end
        return val[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/angle_to_vector_sin_quarter_lut.sv
// ---------------------------------------------------------------------------
// sin_quarter_lut
//   Dual-read quarter-wave sine ROM with registered outputs. Entry i holds
//   round(32767 * sin(i * pi / 2^(LUT_AW+1))), i = 0 .. 2^LUT_AW, so both
//   sin (port a) and cos (port b, fed with 2^LUT_AW - i) come from one table.
//   The table is built at elaboration time; it is the same image the LUT
//   script writes to DEFAULT_LUT_FILE, including the appended entry 2^LUT_AW.
//
//   Ports:
//     clk      system clock
//     resetn   synchronous reset, active low (clears the output registers)
//     en       read enable; outputs hold when low
//     addr_a   read address, port a
//     addr_b   read address, port b
//     data_a   registered sample for addr_a
//     data_b   registered sample for addr_b
// ---------------------------------------------------------------------------
module sin_quarter_lut
    import angle_to_vector_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic [LUT_AW:0]     addr_a,
    input  logic [LUT_AW:0]     addr_b,
    output logic [SAMPLE_W-1:0] data_a,
    output logic [SAMPLE_W-1:0] data_b
);

    localparam int DEPTH  = (1 << LUT_AW) + 1;
    localparam int ROM_W  = DEPTH * SAMPLE_W;

    function automatic logic [ROM_W-1:0] build_rom();
        logic [ROM_W-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r[i*SAMPLE_W +: SAMPLE_W] = sin_q15(i, LUT_AW);
        end
        return r;
    endfunction

    localparam logic [ROM_W-1:0] ROM = build_rom();

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= ROM[int'(addr_a) * SAMPLE_W +: SAMPLE_W];
            data_b <= ROM[int'(addr_b) * SAMPLE_W +: SAMPLE_W];
        end
    end

endmodule

// File: rtl/angle_to_vector.sv
// ---------------------------------------------------------------------------
// angle_to_vector
//   Converts a 16-bit binary angle (0x4000 = 90 deg) and optional magnitude
//   into signed cartesian (x, y) using a quarter-wave sine LUT with quadrant
//   folding. Three pipeline stages, all advanced together by `ready`:
//     stage 1  register quadrant, LUT index (angle truncated), valid, mag
//     stage 2  LUT read: s = L[i], c = L[2^LUT_AW - i]
//     stage 3  optional magnitude scaling, quadrant sign/swap, output regs
//
//   Build option:
//     MAG_SCALE_EN  when defined, stage 3 scales both components by
//                   (L * mag) >> 16; otherwise mag is ignored and outputs
//                   are the unit vector scaled to 32767.
//
//   Ports:
//     clk        system clock
//     resetn     synchronous reset, active low (flushes the pipe)
//     ready      pipeline advance enable; all registers hold when low
//     in_valid   angle/mag valid this cycle
//     angle      unsigned binary angle
//     mag        unsigned magnitude (MAG_SCALE_EN only)
//     x, y       signed cos / sin components, registered
//     out_valid  x/y carry a result from a valid input
// ---------------------------------------------------------------------------
module angle_to_vector
    import angle_to_vector_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      ready,
    input  logic                      in_valid,
    input  logic [ANGLE_W-1:0]        angle,
    input  logic [15:0]               mag,
    output logic signed [15:0]        x,
    output logic signed [15:0]        y,
    output logic                      out_valid
);

    localparam logic [LUT_AW:0] LUT_FULL = {1'b1, {LUT_AW{1'b0}}};

    // stage 1
    quadrant_t           q1;
    logic [LUT_AW-1:0]   i1;
    logic                v1;

    // stage 2
    quadrant_t           q2;
    logic                v2;
    logic [SAMPLE_W-1:0] s2;
    logic [SAMPLE_W-1:0] c2;

    logic [LUT_AW:0]     addr_s;
    logic [LUT_AW:0]     addr_c;

    logic [SAMPLE_W-1:0] s_mag;
    logic [SAMPLE_W-1:0] c_mag;
    logic signed [15:0]  s_pos;
    logic signed [15:0]  c_pos;
    logic signed [15:0]  x_next;
    logic signed [15:0]  y_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q1 <= Q0;
            i1 <= '0;
            v1 <= 1'b0;
        end else if (ready) begin
            q1 <= quadrant_t'(angle[15:14]);
            i1 <= angle[13 -: LUT_AW];
            v1 <= in_valid;
        end
    end

    // Index 0 reads L[2^LUT_AW] = 32767 for the cosine, so the table needs
    // the extra end-point entry and a one-bit-wider address.
    assign addr_s = {1'b0, i1};
    assign addr_c = LUT_FULL - {1'b0, i1};

    sin_quarter_lut #(
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk    (clk),
        .resetn (resetn),
        .en     (ready),
        .addr_a (addr_s),
        .addr_b (addr_c),
        .data_a (s2),
        .data_b (c2)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q2 <= Q0;
            v2 <= 1'b0;
        end else if (ready) begin
            q2 <= q1;
            v2 <= v1;
        end
    end

`ifdef MAG_SCALE_EN
    logic [15:0]             mag1;
    logic [15:0]             mag2;
    logic [SAMPLE_W+15:0]    s_prod;
    logic [SAMPLE_W+15:0]    c_prod;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mag1 <= '0;
            mag2 <= '0;
        end else if (ready) begin
            mag1 <= mag;
            mag2 <= mag1;
        end
    end

    // Unsigned 15x16 product, truncated: full-scale mag gives a 32766 peak.
    assign s_prod = s2 * mag2;
    assign c_prod = c2 * mag2;
    assign s_mag  = s_prod[SAMPLE_W+15:16];
    assign c_mag  = c_prod[SAMPLE_W+15:16];
`else
    logic unused_mag;
    assign unused_mag = ^mag;
    assign s_mag      = s2;
    assign c_mag      = c2;
`endif

    // Magnitudes never exceed 32767, so negation cannot overflow.
    assign s_pos = signed'({1'b0, s_mag});
    assign c_pos = signed'({1'b0, c_mag});

    always_comb begin
        x_next = c_pos;
        y_next = s_pos;
        unique case (q2)
            Q0: begin
                x_next = c_pos;
                y_next = s_pos;
            end
            Q1: begin
                x_next = -s_pos;
                y_next = c_pos;
            end
            Q2: begin
                x_next = -c_pos;
                y_next = -s_pos;
            end
            Q3: begin
                x_next = s_pos;
                y_next = -c_pos;
            end
            default: begin
                x_next = c_pos;
                y_next = s_pos;
            end
        endcase
    end

    // Bubbles still update x/y; only out_valid marks real results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else if (ready) begin
            x         <= x_next;
            y         <= y_next;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_angle_to_vector.sv
module tb_angle_to_vector;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               ready = 1'b0;
    logic               in_valid = 1'b0;
    logic [15:0]        angle = 16'h0000;
    logic [15:0]        mag = 16'h0000;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               out_valid;

    angle_to_vector dut (
        .clk       (clk),
        .resetn    (resetn),
        .ready     (ready),
        .in_valid  (in_valid),
        .angle     (angle),
        .mag       (mag),
        .x         (x),
        .y         (y),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [15:0]        ang;
        int                 adv;
    } exp_t;

    exp_t sb[$];
    int   adv = 0;
    int   checks = 0;
    int   passed = 0;
    bit   last_ready = 1'b0;

    // Reference quarter-wave table from real arithmetic.
    function automatic int lut(input int i);
        real a;
        a = real'(i) * PI / 512.0;
        return $rtoi($floor(32767.0 * $sin(a) + 0.5));
    endfunction

    function automatic void model(input logic [15:0] ang, input logic [15:0] mg,
                                  output logic signed [15:0] ex, output logic signed [15:0] ey);
        int idx;
        longint s;
        longint c;
        idx = int'(ang[13:6]);
        s = longint'(lut(idx));
        c = longint'(lut(256 - idx));
`ifdef MAG_SCALE_EN
        s = (s * longint'(mg)) >>> 16;
        c = (c * longint'(mg)) >>> 16;
`else
        if (mg == 16'h0 && idx < 0) s = 0;
`endif
        case (ang[15:14])
            2'd0: begin ex = 16'(c);  ey = 16'(s);  end
            2'd1: begin ex = 16'(-s); ey = 16'(c);  end
            2'd2: begin ex = 16'(-c); ey = 16'(-s); end
            default: begin ex = 16'(s); ey = 16'(-c); end
        endcase
    endfunction

    // Drive one cycle; records the expectation when the DUT will capture a valid sample.
    task automatic tick(input bit rdy, input bit vld, input logic [15:0] ang, input logic [15:0] mg,
                        input logic signed [15:0] ex, input logic signed [15:0] ey);
        exp_t e;
        ready    = rdy;
        in_valid = vld;
        angle    = ang;
        mag      = mg;
        if (rdy && vld && resetn) begin
            e.x = ex;
            e.y = ey;
            e.ang = ang;
            e.adv = adv;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        last_ready = rdy && resetn;
        if (rdy && resetn) adv++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(1'b0, 1'b1, 16'h1234, 16'hFFFF, 16'sd0, 16'sd0);
        tick(1'b0, 1'b1, 16'h1234, 16'hFFFF, 16'sd0, 16'sd0);
        checks++;
        if (x !== 16'sd0) $display("FAIL reset_x: got %0d, required 0", x); else passed++;
        checks++;
        if (y !== 16'sd0) $display("FAIL reset_y: got %0d, required 0", y); else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid); else passed++;
        resetn = 1'b1;
        tick(1'b1, 1'b0, 16'h0, 16'h0, 16'sd0, 16'sd0);
    endtask

    // Streams samples, optionally stalling before sample index stall_at, and
    // checks order, value, latency (3 ready-high edges) and stall freezing.
    task automatic test_stream(input string name, input logic [15:0] angs[$], input logic [15:0] mg,
                               input logic signed [15:0] exs[$], input logic signed [15:0] eys[$],
                               input int stall_at, input int stall_len);
        int idx = 0;
        int stalled = 0;
        logic signed [15:0] fx = 0;
        logic signed [15:0] fy = 0;
        logic fv = 0;
        exp_t e;
        for (int n = 0; n < 64; n++) begin
            if (idx == stall_at && stalled < stall_len) begin
                if (stalled == 0) begin
                    fx = x; fy = y; fv = out_valid;
                end
                tick(1'b0, 1'b1, 16'hDEAD, mg, 16'sd0, 16'sd0);
                stalled++;
                checks++;
                if (x !== fx || y !== fy || out_valid !== fv)
                    $display("FAIL %s_stall_hold: got (%0d,%0d,%b), required (%0d,%0d,%b)",
                             name, x, y, out_valid, fx, fy, fv);
                else passed++;
            end else if (idx < angs.size()) begin
                tick(1'b1, 1'b1, angs[idx], mg, exs[idx], eys[idx]);
                idx++;
            end else begin
                if (sb.size() == 0) break;
                tick(1'b1, 1'b0, 16'h0, mg, 16'sd0, 16'sd0);
            end
            if (last_ready && out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL %s_extra: got out_valid with (%0d,%0d), required no output", name, x, y);
                end else begin
                    e = sb.pop_front();
                    if (x !== e.x || y !== e.y || (adv - e.adv) != 3)
                        $display("FAIL %s_%h: got (%0d,%0d) latency %0d, required (%0d,%0d) latency 3",
                                 name, e.ang, x, y, adv - e.adv, e.x, e.y);
                    else passed++;
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL %s_drain: got %0d results missing, required 0", name, sb.size());
            sb.delete();
        end else passed++;
    endtask

    task automatic test_axis();
        logic [15:0] a[$] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        logic signed [15:0] ex[$] = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0};
        logic signed [15:0] ey[$] = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32767};
        test_stream("axis", a, 16'hFFFF, ex, ey, -1, 0);
    endtask

    task automatic test_diag();
        logic [15:0] a[$] = '{16'h2000, 16'hE000};
        logic signed [15:0] ex[$] = '{16'sd23170, 16'sd23170};
        logic signed [15:0] ey[$] = '{16'sd23170, -16'sd23170};
        test_stream("diag45", a, 16'hFFFF, ex, ey, -1, 0);
    endtask

    task automatic test_mag_scale();
        logic [15:0] a[$] = '{16'h0000, 16'h0000, 16'h0000};
        logic signed [15:0] ex[$] = '{16'sd32766, 16'sd16383, 16'sd0};
        logic signed [15:0] ey[$] = '{16'sd0, 16'sd0, 16'sd0};
        logic [15:0] m[3] = '{16'hFFFF, 16'h8000, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            logic [15:0] a1[$];
            logic signed [15:0] x1[$];
            logic signed [15:0] y1[$];
            a1.push_back(a[k]);
            x1.push_back(ex[k]);
            y1.push_back(ey[k]);
            test_stream("mag", a1, m[k], x1, y1, -1, 0);
        end
    endtask

    task automatic test_stall();
        logic [15:0] a[$] = '{16'h0000, 16'h4000, 16'h8000};
        logic signed [15:0] ex[$];
        logic signed [15:0] ey[$];
        logic signed [15:0] tx;
        logic signed [15:0] ty;
        for (int k = 0; k < 3; k++) begin
            model(a[k], 16'hFFFF, tx, ty);
            ex.push_back(tx);
            ey.push_back(ty);
        end
        test_stream("stall", a, 16'hFFFF, ex, ey, 2, 5);
        test_stream("stall_late", a, 16'hFFFF, ex, ey, 3, 5);
    endtask

    task automatic test_reset_midflight();
        tick(1'b1, 1'b1, 16'h4000, 16'hFFFF, 16'sd0, 16'sd32767);
        tick(1'b1, 1'b1, 16'h8000, 16'hFFFF, -16'sd32767, 16'sd0);
        resetn = 1'b0;
        tick(1'b1, 1'b0, 16'h0, 16'h0, 16'sd0, 16'sd0);
        sb.delete();
        checks++;
        if (x !== 16'sd0 || y !== 16'sd0 || out_valid !== 1'b0)
            $display("FAIL midflight_reset: got (%0d,%0d,%b), required (0,0,0)", x, y, out_valid);
        else passed++;
        resetn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick(1'b1, 1'b0, 16'h0, 16'h0, 16'sd0, 16'sd0);
            checks++;
            if (out_valid !== 1'b0)
                $display("FAIL midflight_stale_%0d: got out_valid %b, required 0", n, out_valid);
            else passed++;
        end
    endtask

    // Every angle back to back with random ready/in_valid bubbles; +-1 LSB
    // against the real-valued model and an atan2 round trip within 2 LUT steps.
    task automatic test_sweep();
        int a = 0;
        int dx;
        int dy;
        int da;
        bit ok;
        real rt;
        exp_t e;
        logic [15:0] mg;
        logic signed [15:0] tx;
        logic signed [15:0] ty;
        for (int n = 0; n < 90000; n++) begin
`ifdef MAG_SCALE_EN
            mg = 16'($urandom_range(0, 65535));
`else
            mg = 16'hFFFF;
`endif
            if (a >= 65536) begin
                if (sb.size() == 0) break;
                tick(1'b1, 1'b0, 16'h0, mg, 16'sd0, 16'sd0);
            end else if ($urandom_range(0, 15) == 0) begin
                tick(1'b0, 1'b1, 16'hBEEF, mg, 16'sd0, 16'sd0);
            end else if ($urandom_range(0, 15) == 0) begin
                tick(1'b1, 1'b0, 16'hBEEF, mg, 16'sd0, 16'sd0);
            end else begin
                model(16'(a), mg, tx, ty);
                tick(1'b1, 1'b1, 16'(a), mg, tx, ty);
                a++;
            end
            if (last_ready && out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sweep_extra: got out_valid with (%0d,%0d), required no output", x, y);
                end else begin
                    e = sb.pop_front();
                    dx = int'(x) - int'(e.x);
                    dy = int'(y) - int'(e.y);
                    ok = (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1 && (adv - e.adv) == 3);
`ifndef MAG_SCALE_EN
                    rt = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
                    if (rt < 0.0) rt = rt + 65536.0;
                    da = $rtoi($floor(rt + 0.5)) - int'(e.ang);
                    if (da > 32767) da = da - 65536;
                    if (da < -32768) da = da + 65536;
                    if (da < -128 || da > 128) ok = 1'b0;
`else
                    da = 0;
                    rt = 0.0;
`endif
                    if (!ok)
                        $display("FAIL sweep_%h: got (%0d,%0d) latency %0d angle err %0d, required (%0d,%0d)+-1 latency 3",
                                 e.ang, x, y, adv - e.adv, da, e.x, e.y);
                    else passed++;
                end
            end
        end
        checks++;
        if (a != 65536 || sb.size() != 0) begin
            $display("FAIL sweep_complete: got %0d angles sent, %0d pending, required 65536 sent, 0 pending", a, sb.size());
            sb.delete();
        end else passed++;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef MAG_SCALE_EN
        test_mag_scale();
`else
        test_axis();
        test_diag();
`endif
        test_stall();
        test_reset_midflight();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
